uart_rx_word: RTL
=================

Name: uart_rx_word

Overview:
Parametrised UART receiver and word assembler, the successor to the fixed 8N1 byte receiver that feeds the half-precision FPU FSM. It adds runtime bit timing, configurable data bits and parity, and error detection. Received bytes are packed little-endian into WORD_BYTES-wide operand words, delivered on a valid/ready handshake with a one-entry holding register. It sits between the pad/LA-muxed serial input and the FPU command/operand loader.

Parameters:
DATA_BITS, 8, data bits per character (5..8), sent LSB first
PARITY, 0, 0 = none, 1 = even, 2 = odd
WORD_BYTES, 2, characters packed per output word (1..4)
TIMEOUT_BITS, 32, idle bit-times after which a partial word is discarded
CPB_W, 16, width of the runtime clocks-per-bit input

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx_i  input  1  asynchronous serial input, idle high
clks_per_bit  input  CPB_W  clock cycles per bit; latched at each start-bit detect
word_o  output  DATA_BITS*WORD_BYTES  assembled word; first character in the least-significant bits
word_valid_o  output  1  word_o holds an unconsumed word
word_ready_i  input  1  consumer accepts word_o when high together with word_valid_o
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
parity_err_o  output  1  one-cycle pulse: parity mismatch
overrun_o  output  1  sticky: a completed word was dropped
clr_i  input  1  synchronous clear of overrun_o
busy_o  output  1  FSM not in IDLE, or partial word pending

Behaviour:
- Reset (async, active-high): state IDLE; word_o=0; word_valid_o=0; all error outputs=0; busy_o=0; byte index=0; synchroniser flops=1. Reset mid-frame drops the frame and any partial word.
- rx_i passes through a 2-flop synchroniser. All edges and samples below refer to the synchronised signal.
- Effective bit period: cpb = max(latched clks_per_bit, 4). Values 0..3 behave as 4.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE -> START on a synchronised high-to-low transition. Latch clks_per_bit and clear the bit counter.
  - START: wait cpb>>1 cycles, then sample. A high sample is a false start: return to IDLE with no outputs. A low sample goes to DATA.
  - DATA: sample every cpb cycles and shift LSB-first. After DATA_BITS samples, go to PARITY if PARITY!=0, else to STOP.
  - PARITY: sample once, one cpb after the last data sample. Compare against the even/odd parity of the data bits and record any mismatch. Go to STOP.
  - STOP: sample once.
    - Low sample: pulse frame_err_o, discard the character and the partial word, reset the byte index, go to BREAK.
    - High sample with a recorded parity mismatch: pulse parity_err_o, discard the character and the partial word, return to IDLE.
    - Otherwise the character is accepted; return to IDLE.
  - BREAK: stay until the line is high, then go to IDLE.
- Assembly: an accepted character is written to byte slot [index], then the index increments. When index reaches WORD_BYTES, the word is complete and the index returns to 0.
- Output latency: word_valid_o rises on the cycle after the stop-bit sample of the final character.
- Handshake:
  - word_valid_o and word_o stay stable until the cycle with word_valid_o && word_ready_i.
  - word_valid_o falls on the next cycle, unless a new word completes in that same cycle. In that case the new word loads and word_valid_o stays high.
- Overrun: a word completes while word_valid_o=1 and word_ready_i=0. The new word is dropped, the held word is kept, and overrun_o is set.
  - clr_i clears overrun_o.
  - If clr_i and a new overrun occur in the same cycle, set wins.
- Timeout: with index!=0 and the FSM in IDLE, count cycles. After TIMEOUT_BITS*cpb cycles with no start detected, discard the partial word and set index to 0. The counter restarts on every start detect.
- Error pulses are exactly one cycle wide and never assert together.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum.
  - Parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
  - Minimum-cpb constant CPB_MIN=4.
- One natural sub-module: uart_rx_core. It contains the synchroniser, the bit FSM and the error detection, and emits a char_valid pulse with the character data.
- uart_rx_word contains the assembler, the holding register, overrun and timeout.

Test Plan:
- Nominal frame: DATA_BITS=8, PARITY=0, WORD_BYTES=2, clks_per_bit=16. Send 0x00 then 0x3C. Required: word_o=16'h3C00 with word_valid_o high 1 cycle after the second stop sample; no error pulses.
- Parity error: PARITY=1, clks_per_bit=16. Send 0xA5 with parity bit 1 (correct even parity is 0). Required: one parity_err_o pulse, no word, and the next good 2-byte pair (0x34, 0x12) yields 16'h1234.
- Framing error: drive the stop bit low and hold rx low for 40 cycles. Required: one frame_err_o pulse, FSM stays in BREAK until rx rises, and the partial word is discarded.
- Glitch and clamping:
  - A 5-cycle low glitch with clks_per_bit=16 produces no output and busy_o returns low.
  - clks_per_bit=2 receives correctly at the 4-cycle bit period.
- Overrun: hold word_ready_i=0 and send two complete words 0x1111 then 0x2222. Required: word_o remains 0x1111 and overrun_o=1. Pulse clr_i: overrun_o=0.
- Timeout and reset: send one byte 0x55 then idle 32*16 cycles. Required: index resets, and the next pair 0x01, 0x02 yields 0x0201. Assert rst mid-DATA: all outputs 0 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: bit-FSM state codes, parity modes, minimum bit period.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;
    localparam state_t ST_BREAK  = 3'd5;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Shortest usable bit period. Half of it must still leave room for the start-bit check.
    localparam int CPB_MIN = 4;

endpackage

// File: rtl/uart_rx_core.sv
// UART bit engine: synchroniser, start/data/parity/stop FSM, framing and parity error detection.
// Latency: char_vld is asserted combinationally in the cycle whose clock edge takes the stop-bit sample.
// Backpressure: none. Characters and error pulses are fire-and-forget, and the consumer must keep up.
//
// Ports:
//   clk, rst      system clock, async active-high reset
//   rx_i          raw serial input, idle high
//   clks_per_bit  bit period in clocks, latched at start detect and clamped to CPB_MIN
//   char_vld/dat  one-cycle strobe with an accepted character
//   frame_err     one-cycle pulse: stop bit sampled low
//   parity_err    one-cycle pulse: parity mismatch on an otherwise well-framed character
//   idle          FSM is in IDLE
//   start_det     start edge detected this cycle
//   cpb           bit period latched for the current/last frame
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int CPB_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    input  logic [CPB_W-1:0]     clks_per_bit,
    output logic                 char_vld,
    output logic [DATA_BITS-1:0] char_dat,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 idle,
    output logic                 start_det,
    output logic [CPB_W-1:0]     cpb
);

    localparam int BCW = 4;

    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_prev;
    state_t               state;
    logic [CPB_W-1:0]     cpb_q;
    logic [CPB_W-1:0]     cnt;
    logic [CPB_W-1:0]     tgt;
    logic [CPB_W-1:0]     cpb_eff;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bad;
    logic                 tick;
    logic                 fall;
    logic                 par_mis;

    // Two flops for metastability, a third only to find the falling edge of the clean signal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign fall    = rx_prev & ~rx_s2;
    assign cpb_eff = (clks_per_bit < CPB_W'(CPB_MIN)) ? CPB_W'(CPB_MIN) : clks_per_bit;

    // START waits half a bit so that every later sample lands mid-bit.
    assign tgt  = (state == ST_START) ? (cpb_q >> 1) : cpb_q;
    assign tick = (cnt == tgt - CPB_W'(1));

    // The received parity bit XORed with the data is 0 for even parity and 1 for odd parity.
    assign par_mis = rx_s2 ^ (^shift_q) ^ (PARITY == PAR_ODD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cpb_q      <= CPB_W'(CPB_MIN);
            cnt        <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (state != ST_IDLE && state != ST_BREAK) begin
                cnt <= tick ? '0 : cnt + CPB_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state   <= ST_START;
                        cpb_q   <= cpb_eff;
                        cnt     <= '0;
                        par_bad <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state   <= rx_s2 ? ST_IDLE : ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_q <= {rx_s2, shift_q[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BCW'(1);
                        if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                            state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        par_bad <= par_mis;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (!rx_s2) begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end else begin
                            parity_err <= par_bad;
                            state      <= ST_IDLE;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_s2) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign char_vld  = (state == ST_STOP) && tick && rx_s2 && !par_bad;
    assign char_dat  = shift_q;
    assign idle      = (state == ST_IDLE);
    assign start_det = (state == ST_IDLE) && fall;
    assign cpb       = cpb_q;

endmodule

// File: rtl/uart_rx_word.sv
// UART receiver that packs characters little-endian into words, with overrun and partial-word timeout.
// Latency: word_valid_o rises the cycle after the stop-bit sample of the last character of a word.
// Backpressure: one-entry holding register on valid/ready. A word completing while it is full is dropped and flags overrun.
//
// Ports:
//   clk, rst          system clock, async active-high reset
//   rx_i              serial input, idle high
//   clks_per_bit      runtime bit period (values below 4 act as 4)
//   word_o            assembled word, first character in the LSBs
//   word_valid_o      word_o holds an unconsumed word
//   word_ready_i      consumer takes word_o when high with word_valid_o
//   frame_err_o       one-cycle pulse on a low stop bit
//   parity_err_o      one-cycle pulse on a parity mismatch
//   overrun_o         sticky: a completed word was dropped
//   clr_i             synchronous clear of overrun_o (a same-cycle new overrun wins)
//   busy_o            a frame is in progress or a partial word is pending
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int WORD_BYTES   = 2,
    parameter int TIMEOUT_BITS = 32,
    parameter int CPB_W        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx_i,
    input  logic [CPB_W-1:0]                clks_per_bit,
    output logic [DATA_BITS*WORD_BYTES-1:0] word_o,
    output logic                            word_valid_o,
    input  logic                            word_ready_i,
    output logic                            frame_err_o,
    output logic                            parity_err_o,
    output logic                            overrun_o,
    input  logic                            clr_i,
    output logic                            busy_o
);

    localparam int WORD_W = DATA_BITS * WORD_BYTES;
    localparam int IW     = 3;
    localparam int TW     = CPB_W + $clog2(TIMEOUT_BITS + 1);

    logic                 char_vld;
    logic [DATA_BITS-1:0] char_dat;
    logic                 core_idle;
    logic                 start_det;
    logic [CPB_W-1:0]     cpb;
    logic [IW-1:0]        idx;
    logic [WORD_W-1:0]    asm_q;
    logic [WORD_W-1:0]    next_asm;
    logic [TW-1:0]        tmo_cnt;
    logic [TW-1:0]        tmo_lim;
    logic                 tmo_exp;
    logic                 word_done;
    logic                 ovr_set;

    uart_rx_core #(
        .DATA_BITS (DATA_BITS),
        .PARITY    (PARITY),
        .CPB_W     (CPB_W)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .clks_per_bit (clks_per_bit),
        .char_vld     (char_vld),
        .char_dat     (char_dat),
        .frame_err    (frame_err_o),
        .parity_err   (parity_err_o),
        .idle         (core_idle),
        .start_det    (start_det),
        .cpb          (cpb)
    );

    // Assembly buffer with the incoming character dropped into its slot. On the last slot this
    // is the complete word, loaded straight into the holding register.
    always_comb begin
        next_asm = asm_q;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (IW'(i) == idx) begin
                next_asm[i*DATA_BITS +: DATA_BITS] = char_dat;
            end
        end
    end

    assign word_done = char_vld && (idx == IW'(WORD_BYTES - 1));
    assign ovr_set   = word_done && word_valid_o && !word_ready_i;

    // Timeout is measured in bit-times of the last received frame.
    assign tmo_lim = TW'(TIMEOUT_BITS) * TW'(cpb);
    assign tmo_exp = core_idle && (idx != '0) && !start_det && (tmo_cnt == tmo_lim - TW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (!core_idle || idx == '0 || start_det || tmo_exp) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            asm_q <= '0;
        end else if (frame_err_o || parity_err_o || tmo_exp) begin
            idx <= '0;
        end else if (char_vld) begin
            asm_q <= next_asm;
            idx   <= word_done ? '0 : idx + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_o       <= '0;
            word_valid_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            if (word_done && (!word_valid_o || word_ready_i)) begin
                word_o       <= next_asm;
                word_valid_o <= 1'b1;
            end else if (word_ready_i) begin
                word_valid_o <= 1'b0;
            end
            if (ovr_set) begin
                overrun_o <= 1'b1;
            end else if (clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    assign busy_o = !core_idle || (idx != '0);

endmodule
